// File: rtl/phase_a_pkg.sv
// Shared phase_a constants: operand geometry, call count and
// sequencer state encodings.
package phase_a_pkg;

  localparam int unsigned PA_SIZE    = 3072;
  localparam int unsigned PA_RADIX   = 54;
  localparam int unsigned PA_ITER    = 57;
  localparam int unsigned PA_TIMEOUT = 200;

  typedef enum logic [2:0] {
    PA_IDLE  = 3'd0,
    PA_ISSUE = 3'd1,
    PA_WAIT  = 3'd2,
    PA_GAP   = 3'd3,
    PA_DONE  = 3'd4
  } pa_state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/phase_a_seq.sv
// Sequencer issuing ITER phase_a calls over a working operand,
// with a per-call watchdog and abort.
module phase_a_seq
  import phase_a_pkg::*;
#(
  parameter int unsigned SIZE    = PA_SIZE,
  parameter int unsigned RADIX   = PA_RADIX,
  parameter int unsigned ITER    = PA_ITER,
  parameter int unsigned TIMEOUT = PA_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SIZE-1:0]  a_in,
  input  logic [SIZE-1:0]  m_in,
  input  logic [SIZE+1:0]  m_n_in,
  input  logic [RADIX+1:0] m_prime_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SIZE-1:0]  result,
  output logic [SIZE-1:0]  pa_a,
  output logic [SIZE-1:0]  pa_m,
  output logic [SIZE+1:0]  pa_m_n,
  output logic [RADIX+1:0] pa_m_prime,
  output logic             pa_en,
  input  logic             pa_en_out,
  input  logic [SIZE-1:0]  pa_new_a
);

  localparam int unsigned CW = cnt_w(ITER);
  localparam int unsigned TW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] ITER_C = CW'(ITER);
  localparam logic [TW-1:0] TMO_C  = TW'(TIMEOUT - 1);

  pa_state_e state_q, state_d;

  logic [SIZE-1:0]  work_q, work_d;
  logic [SIZE-1:0]  m_q, m_d;
  logic [SIZE+1:0]  mn_q, mn_d;
  logic [RADIX+1:0] mp_q, mp_d;
  logic [SIZE-1:0]  res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             gap_q, gap_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    m_d     = m_q;
    mn_d    = mn_q;
    mp_d    = mp_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    err_d   = err_q;
    // abort wins over everything, including a coincident capture
    if (abort && state_q != PA_IDLE) begin
      state_d = PA_IDLE;
    end else begin
      unique case (state_q)
        PA_IDLE: begin
          if (start && !abort) begin
            work_d  = a_in;
            m_d     = m_in;
            mn_d    = m_n_in;
            mp_d    = m_prime_in;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = PA_ISSUE;
          end
        end
        PA_ISSUE: begin
          tmr_d   = '0;
          state_d = PA_WAIT;
        end
        PA_WAIT: begin
          if (pa_en_out) begin
            work_d  = pa_new_a;
            cnt_d   = cnt_q + CW'(1);
            gap_d   = 1'b0;
            state_d = (cnt_d == ITER_C) ? PA_DONE : PA_GAP;
          end else if (tmr_q == TMO_C) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            res_d   = work_q;
            state_d = PA_IDLE;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        PA_GAP: begin
          gap_d = 1'b1;
          if (gap_q) state_d = PA_ISSUE;
        end
        PA_DONE: begin
          res_d   = work_q;
          done_d  = 1'b1;
          state_d = PA_IDLE;
        end
        default: state_d = PA_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PA_IDLE;
      work_q  <= '0;
      m_q     <= '0;
      mn_q    <= '0;
      mp_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      gap_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      m_q     <= m_d;
      mn_q    <= mn_d;
      mp_q    <= mp_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q != PA_IDLE);
  assign pa_en      = (state_q == PA_ISSUE);
  assign done       = done_q;
  assign err        = err_q;
  assign result     = res_q;
  assign pa_a       = work_q;
  assign pa_m       = m_q;
  assign pa_m_n     = mn_q;
  assign pa_m_prime = mp_q;

endmodule
